edge_turn_sequencer: RTL

Border-avoidance sequencer for the drive path. It watches the left and right border sensors. On a border hit it backs the robot up, pivots it away from the edge, and then pulses a turn-complete/fire strobe. Its outputs are the border-cross and edge-turn motor direction nibbles, `turn_start` and `t_c`, which the motor-select overlord consumes while in pursuit (PR) mode.

---
 rtl/edge_turn_sequencer_if.sv | 23 ++
 rtl/edge_turn_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/edge_turn_sequencer_if.sv
// Drive-path signals between the border sequencer (master) and the motor-select overlord (slave).
// Motor nibbles are indexed [4:1] so bit n is INn.
interface edge_turn_sequencer_if;
  logic       enable;
  logic       pr;
  logic       border_l;
  logic       border_r;
  logic [4:1] bc_in;
  logic [4:1] et_in;
  logic       turn_start;
  logic       t_c;
  logic       busy;

  modport master (
    input  enable, pr, border_l, border_r,
    output bc_in, et_in, turn_start, t_c, busy
  );

  modport slave (
    output enable, pr, border_l, border_r,
    input  bc_in, et_in, turn_start, t_c, busy
  );
endinterface

// File: rtl/edge_turn_sequencer.sv
// Border-avoidance sequencer: reverse, pivot away from the edge, then pulse t_c; outputs registered off next state.
// Define EDGE_TURN_DEBOUNCE_EN to insert a DEB_CYCLES consecutive-sample debounce after the synchronizers.
module edge_turn_sequencer #(
  parameter int REVERSE_CYCLES = 25_000_000,
  parameter int TURN_CYCLES    = 50_000_000,
  parameter int FIRE_CYCLES    = 1_000_000,
  parameter int DEB_CYCLES     = 1_000,
  parameter int CNT_W          = 28
) (
  input logic                  clk,
  input logic                  rst_n,
  edge_turn_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REVERSE, S_TURN, S_DONE} state_t;

  localparam logic [4:1] MOT_FWD   = 4'b0101;
  localparam logic [4:1] MOT_REV   = 4'b1010;
  localparam logic [4:1] PIV_RIGHT = 4'b0110;
  localparam logic [4:1] PIV_LEFT  = 4'b1001;

  localparam logic [CNT_W-1:0] REV_LOAD   = CNT_W'(REVERSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN2_LOAD = CNT_W'(2 * TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRE_LOAD  = CNT_W'(FIRE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             piv_left_q, piv_left_d;
  logic             both_q, both_d;
  logic [1:0]       sync_l_q, sync_l_d;
  logic [1:0]       sync_r_q, sync_r_d;
  logic [4:1]       bc_in_q, bc_in_d;
  logic [4:1]       et_in_q, et_in_d;
  logic             turn_start_q, turn_start_d;
  logic             t_c_q, t_c_d;
  logic             busy_q, busy_d;

  logic             hit_l, hit_r;
  logic             run;
  logic             start_rev;

  assign sync_l_d = {sync_l_q[0], bus.border_l};
  assign sync_r_d = {sync_r_q[0], bus.border_r};

`ifdef EDGE_TURN_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  logic [DEB_W-1:0] deb_l_q, deb_l_d;
  logic [DEB_W-1:0] deb_r_q, deb_r_d;

  // Saturating run-length of consecutive high samples; any low sample restarts it.
  always_comb begin
    deb_l_d = '0;
    deb_r_d = '0;
    if (sync_l_q[1]) deb_l_d = (deb_l_q == DEB_MAX) ? DEB_MAX : deb_l_q + DEB_W'(1);
    if (sync_r_q[1]) deb_r_d = (deb_r_q == DEB_MAX) ? DEB_MAX : deb_r_q + DEB_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_l_q <= '0;
      deb_r_q <= '0;
    end else begin
      deb_l_q <= deb_l_d;
      deb_r_q <= deb_r_d;
    end
  end

  assign hit_l = (deb_l_q == DEB_MAX);
  assign hit_r = (deb_r_q == DEB_MAX);
`else
  assign hit_l = sync_l_q[1];
  assign hit_r = sync_r_q[1];
`endif

  assign run       = bus.enable && bus.pr;
  assign start_rev = (hit_l || hit_r) && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    piv_left_d = piv_left_q;
    both_d     = both_q;

    if (!run) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      piv_left_d = 1'b0;
      both_d     = 1'b0;
    end else if (start_rev) begin
      state_d    = S_REVERSE;
      cnt_d      = REV_LOAD;
      piv_left_d = hit_r && !hit_l;
      both_d     = hit_l && hit_r;
    end else if (state_q != S_IDLE) begin
      // Counter holds at zero in IDLE, so the phase advance only ever happens from a loaded state.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        case (state_q)
          S_REVERSE: begin
            state_d = S_TURN;
            cnt_d   = both_q ? TURN2_LOAD : TURN_LOAD;
          end
          S_TURN: begin
            state_d = S_DONE;
            cnt_d   = FIRE_LOAD;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    bc_in_d      = MOT_FWD;
    et_in_d      = '0;
    turn_start_d = 1'b0;
    t_c_d        = 1'b0;
    busy_d       = (state_d != S_IDLE);
    case (state_d)
      S_REVERSE: bc_in_d = MOT_REV;
      S_TURN: begin
        bc_in_d      = MOT_REV;
        et_in_d      = piv_left_d ? PIV_LEFT : PIV_RIGHT;
        turn_start_d = 1'b1;
      end
      S_DONE:  t_c_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_l_q     <= '0;
      sync_r_q     <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      piv_left_q   <= 1'b0;
      both_q       <= 1'b0;
      bc_in_q      <= MOT_FWD;
      et_in_q      <= '0;
      turn_start_q <= 1'b0;
      t_c_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_l_q     <= sync_l_d;
      sync_r_q     <= sync_r_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      piv_left_q   <= piv_left_d;
      both_q       <= both_d;
      bc_in_q      <= bc_in_d;
      et_in_q      <= et_in_d;
      turn_start_q <= turn_start_d;
      t_c_q        <= t_c_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.bc_in      = bc_in_q;
  assign bus.et_in      = et_in_q;
  assign bus.turn_start = turn_start_q;
  assign bus.t_c        = t_c_q;
  assign bus.busy       = busy_q;

endmodule
